// File: rtl/prog_loader.sv
// prog_loader: writer side of the processor's program memory.
// Receives a byte-serial program image (LEN_HI, LEN_LO, N x {DATA_HI, DATA_LO}, CHK)
// from the UART receiver and writes it word-by-word into program memory. While a
// load runs the CPU is held; completion (good or bad) is flagged by done_tick and
// a sticky err.
//
// Ports:
//   clk          system clock, all state updated on posedge
//   reset_n      asynchronous active-low reset
//   start        one-cycle load request, honoured only in IDLE
//   rx_data      received byte, valid with rx_done_tick
//   rx_done_tick one-cycle strobe per received byte
//   wr_en        one-cycle program-memory write strobe
//   addr         program-memory write address (W bits)
//   w_data       program-memory write data (B bits)
//   busy         load in progress
//   cpu_hold     holds the CPU in reset, same timing as busy
//   done_tick    one-cycle pulse when a load ends
//   err          sticky error flag, cleared by the next accepted start
module prog_loader #(
    parameter int B = 16,
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [7:0]   rx_data,
    input  logic         rx_done_tick,
    output logic         wr_en,
    output logic [W-1:0] addr,
    output logic [B-1:0] w_data,
    output logic         busy,
    output logic         cpu_hold,
    output logic         done_tick,
    output logic         err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DAT_HI = 3'd3,
        S_DAT_LO = 3'd4,
        S_CHK    = 3'd5,
        S_FIN    = 3'd6
    } state_t;

    // Largest legal word count (the full memory) and the last address.
    localparam logic [16:0]  MAX_N    = 17'(2 ** W);
    localparam logic [W-1:0] ADDR_MAX = {W{1'b1}};

    // Running checksum update: XOR of data bytes.
    function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t       state_q, state_d;
    logic [7:0]   len_hi_q, len_hi_d;
    logic [15:0]  n_q, n_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [7:0]   chk_q, chk_d;
    logic [7:0]   dat_hi_q, dat_hi_d;
    logic         wr_en_q, wr_en_d;
    logic [W-1:0] addr_q, addr_d;
    logic [B-1:0] w_data_q, w_data_d;
    logic         busy_q, busy_d;
    logic         cpu_hold_q, cpu_hold_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic [15:0]  n_word_s;

    assign n_word_s = {len_hi_q, rx_data};

    // Next-state and registered-output logic for the frame parser.
    always_comb begin
        state_d    = state_q;
        len_hi_d   = len_hi_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        chk_d      = chk_q;
        dat_hi_d   = dat_hi_q;
        wr_en_d    = 1'b0;
        w_data_d   = w_data_q;
        busy_d     = busy_q;
        cpu_hold_d = cpu_hold_q;
        done_d     = 1'b0;
        err_d      = err_q;
        // Address advances the cycle after each write; saturates on the last word
        // so a full-memory load leaves addr at the top instead of wrapping.
        if (wr_en_q && (addr_q != ADDR_MAX)) begin
            addr_d = addr_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            addr_d = addr_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LEN_HI;
                    busy_d     = 1'b1;
                    cpu_hold_d = 1'b1;
                    err_d      = 1'b0;
                    addr_d     = '0;
                    chk_d      = 8'h00;
                    cnt_d      = 16'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LEN_HI: begin
                if (rx_done_tick) begin
                    len_hi_d = rx_data;
                    state_d  = S_LEN_LO;
                end else begin
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_LO: begin
                if (rx_done_tick) begin
                    n_d = n_word_s;
                    if ((n_word_s == 16'd0) || ({1'b0, n_word_s} > MAX_N)) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        state_d = S_DAT_HI;
                    end
                end else begin
                    state_d = S_LEN_LO;
                end
            end
            S_DAT_HI: begin
                if (rx_done_tick) begin
                    dat_hi_d = rx_data;
                    chk_d    = chk_fold(chk_q, rx_data);
                    state_d  = S_DAT_LO;
                end else begin
                    state_d = S_DAT_HI;
                end
            end
            S_DAT_LO: begin
                if (rx_done_tick) begin
                    chk_d    = chk_fold(chk_q, rx_data);
                    wr_en_d  = 1'b1;
                    w_data_d = {dat_hi_q, rx_data};
                    cnt_d    = cnt_q + 16'd1;
                    // n_q never exceeds 2**W, so the increment cannot overflow.
                    if ((cnt_q + 16'd1) == n_q) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_DAT_HI;
                    end
                end else begin
                    state_d = S_DAT_LO;
                end
            end
            S_CHK: begin
                if (rx_done_tick) begin
                    if (rx_data != chk_q) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end else begin
                    state_d = S_CHK;
                end
            end
            S_FIN: begin
                busy_d     = 1'b0;
                cpu_hold_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            len_hi_q   <= 8'h00;
            n_q        <= 16'd0;
            cnt_q      <= 16'd0;
            chk_q      <= 8'h00;
            dat_hi_q   <= 8'h00;
            wr_en_q    <= 1'b0;
            addr_q     <= '0;
            w_data_q   <= '0;
            busy_q     <= 1'b0;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_hi_q   <= len_hi_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            chk_q      <= chk_d;
            dat_hi_q   <= dat_hi_d;
            wr_en_q    <= wr_en_d;
            addr_q     <= addr_d;
            w_data_q   <= w_data_d;
            busy_q     <= busy_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign addr      = addr_q;
    assign w_data    = w_data_q;
    assign busy      = busy_q;
    assign cpu_hold  = cpu_hold_q;
    assign done_tick = done_q;
    assign err       = err_q;

endmodule
